// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store unit with lane steering, load extension, error and timeout detection
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [1:0]        i_data_size,
    input  logic              i_load_signed,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic              o_stall,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic [1:0]        o_err_code,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [3:0]        o_bus_be,
    output logic [31:0]       o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [31:0]       i_bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam logic [1:0]  SZ_BYTE = 2'b00;
    localparam logic [1:0]  SZ_HALF = 2'b01;
    localparam logic [1:0]  SZ_WORD = 2'b11;
    localparam logic [1:0]  ERR_OK  = 2'b00;
    localparam logic [1:0]  ERR_MIS = 2'b01;
    localparam logic [1:0]  ERR_TO  = 2'b10;
    localparam logic [1:0]  ERR_ILL = 2'b11;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cnt;
    logic [1:0]  r_size;
    logic [1:0]  r_off;
    logic        r_signed;
    logic        w_start;
    logic        w_timeout;
    logic [1:0]  w_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;

    assign w_start   = i_mem_read | i_mem_write;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == TO_LAST);
    assign o_stall   = ((r_state == S_IDLE) && w_start) || (r_state == S_REQ);

    // Classify a new request: illegal combinations win over misalignment
    always_comb begin
        w_err = ERR_OK;
        if ((i_mem_read && i_mem_write) || (i_data_size == 2'b10)) begin
            w_err = ERR_ILL;
        end else if (((i_data_size == SZ_HALF) && i_addr[0]) ||
                     ((i_data_size == SZ_WORD) && (i_addr[1:0] != 2'b00))) begin
            w_err = ERR_MIS;
        end
    end

    // Byte-enable generation and store-data lane replication
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = i_wdata;
        case (i_data_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << i_addr[1:0];
                w_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{i_wdata[15:0]}};
            end
            SZ_WORD: w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // Extract the addressed lane from read data and extend it
    always_comb begin
        case (r_off)
            2'd0:    w_byte = i_bus_rdata[7:0];
            2'd1:    w_byte = i_bus_rdata[15:8];
            2'd2:    w_byte = i_bus_rdata[23:16];
            default: w_byte = i_bus_rdata[31:24];
        endcase
        w_half = r_off[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (r_size)
            SZ_BYTE: w_load = {{24{r_signed & w_byte[7]}}, w_byte};
            SZ_HALF: w_load = {{16{r_signed & w_half[15]}}, w_half};
            default: w_load = i_bus_rdata;
        endcase
    end

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; an ack in the final REQ cycle beats the timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = (w_err != ERR_OK) ? S_DONE : S_REQ;
            S_REQ:   if (i_bus_ack || w_timeout) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Registered bus signals, completion status, load result and wait counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_bus_req   <= 1'b0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= '0;
            o_bus_be    <= 4'b0000;
            o_bus_wdata <= 32'h0;
            o_done      <= 1'b0;
            o_rdata     <= 32'h0;
            o_err_code  <= ERR_OK;
            r_cnt       <= 32'h0;
            r_size      <= 2'b00;
            r_off       <= 2'b00;
            r_signed    <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    o_bus_we    <= i_mem_write;
                    o_bus_addr  <= {i_addr[ADDR_W-1:2], 2'b00};
                    o_bus_be    <= w_be;
                    o_bus_wdata <= w_wdata;
                    r_size      <= i_data_size;
                    r_off       <= i_addr[1:0];
                    r_signed    <= i_load_signed;
                    r_cnt       <= 32'h0;
                    if (w_err != ERR_OK) begin
                        o_done     <= 1'b1;
                        o_err_code <= w_err;
                    end else begin
                        o_bus_req <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (i_bus_ack) begin
                        o_bus_req  <= 1'b0;
                        o_done     <= 1'b1;
                        o_err_code <= ERR_OK;
                        if (!o_bus_we) o_rdata <= w_load;
                    end else if (w_timeout) begin
                        o_bus_req  <= 1'b0;
                        o_done     <= 1'b1;
                        o_err_code <= ERR_TO;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Load/store stage directly downstream of the control unit; consumes mem_read, mem_write and data_size from it, plus the ALU-computed address and the store data.
- Runs a request/acknowledge transaction with data memory, performs byte-lane steering and load extension, and stalls the datapath until the access completes.
- Detects misaligned, illegal and timed-out accesses and reports them through an error code.

Parameters:
TIMEOUT_CYCLES, 255, REQ cycles without mem_ack before the access aborts; 0 disables the timeout
ADDR_W, 32, address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
mem_read  in  1  load request from control unit
mem_write  in  1  store request from control unit
data_size  in  2  00 byte, 01 half, 11 word, 10 reserved
load_signed  in  1  1 = sign-extend byte/half loads, 0 = zero-extend
addr  in  ADDR_W  byte address (ALU result)
wdata  in  32  store data, right-justified
stall  out  1  hold upstream pipeline
done  out  1  one-cycle completion pulse
rdata  out  32  extended load result, valid when done
err_code  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal; valid when done
bus_req  out  1  memory request
bus_we  out  1  1 = write
bus_addr  out  ADDR_W  word-aligned address, addr with [1:0] forced to 00
bus_be  out  4  byte enables, little-endian
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  memory acknowledge, single-cycle
bus_rdata  in  32  read data, valid with bus_ack

Behaviour:
- Reset (asynchronous, active-high): state goes to IDLE; all registered outputs go to 0 immediately (bus_req, bus_we, bus_addr, bus_be, bus_wdata, done, rdata, err_code) and the timeout counter clears. A reset mid-transaction drops bus_req at once and abandons the access with no done pulse.
- FSM states: IDLE, REQ, DONE.
- IDLE, start of an access:
  - When mem_read or mem_write is high, the unit latches addr, wdata, data_size and load_signed.
  - Error check, in priority order:
    - both mem_read and mem_write high, or data_size 10 -> err 11;
    - half with addr[0]=1, or word with addr[1:0]!=00 -> err 01.
  - On error the FSM goes to DONE and no bus_req is issued; otherwise it goes to REQ.
- stall is combinational: high when (state IDLE and (mem_read or mem_write)) or state REQ; low in DONE.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_be and bus_wdata are held stable until acknowledge.
  - On bus_ack, a load captures its extended result into rdata; the FSM goes to DONE with err 00.
  - The timeout counter clears on entry and increments every REQ cycle without bus_ack. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1 with no ack, bus_req drops and the FSM goes to DONE with err 10. An ack in that same cycle takes priority over the timeout.
- DONE: done=1 for exactly one cycle, then the FSM returns to IDLE. A new request can be accepted in the following IDLE cycle.
- Latency: request seen in cycle 0 -> bus_req in cycle 1 -> ack in cycle 1 -> done in cycle 2. The minimum is 2 cycles; each wait-state adds 1. Error accesses complete in 1 cycle (done in cycle 1).
- Lane steering, with off = addr[1:0]:
  - byte: bus_be = 0001 << off; bus_wdata = {4{wdata[7:0]}}.
  - half: bus_be = 0011 (off 0) or 1100 (off 2); bus_wdata = {2{wdata[15:0]}}.
  - word: bus_be = 1111; bus_wdata = wdata.
  - Loads use the same bus_be.
- Load extraction: byte = bus_rdata[8*off+7 : 8*off]; half = bus_rdata[16*off[1]+15 : 16*off[1]]; the result is sign- or zero-extended to 32 bits per load_signed. Word loads pass through unchanged.
- rdata holds its value until the next successful load; stores, errors and timeouts leave it unchanged.
- bus_ack outside REQ is ignored.
- Request inputs that change while the unit is in REQ or DONE are ignored; upstream holds them under stall.

Test Plan:
1. Word load, addr=0x100, ack in the cycle after bus_req rises, bus_rdata=0xDEADBEEF -> bus_addr=0x100, bus_be=1111, done in cycle 2, rdata=0xDEADBEEF, err 00.
2. Signed byte load, addr=0x103, bus_rdata=0x80112233 -> bus_be=1000, rdata=0xFFFFFF80; repeat with load_signed=0 -> rdata=0x00000080.
3. Half store, addr=0x202, wdata=0x0000ABCD, 3 wait-states -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD held stable for 4 cycles, done 5 cycles after the request, rdata unchanged.
4. Misaligned and illegal accesses:
   - Word load at addr=0x101 -> no bus_req, done in cycle 1, err 01.
   - mem_read=mem_write=1 -> err 11.
   - data_size=10 -> err 11.
5. Timeout with TIMEOUT_CYCLES=4 and no ack -> bus_req high for 4 cycles, then drops; done with err 10. Separately, ack on the 4th REQ cycle -> err 00.
6. rst asserted during the 2nd REQ cycle -> bus_req=0 asynchronously, no done pulse. After release, a word load completes normally with err 00.
